// File: rtl/edge_req_arbiter_if.sv
// -----------------------------------------------------------------------------
// edge_req_arbiter_if
//   Grant handshake between edge_req_arbiter and the shared resource it feeds.
//
//   Signals:
//     gnt_valid  arbiter -> resource : a grant is being presented
//     gnt_id     arbiter -> resource : channel being granted, stable while valid
//     gnt_ready  resource -> arbiter : resource accepts the current grant
//
//   Modports:
//     master : arbiter side (drives gnt_valid / gnt_id)
//     slave  : resource side (drives gnt_ready)
// -----------------------------------------------------------------------------
interface edge_req_arbiter_if #(
    parameter int unsigned IDW = 2
) ();

    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           gnt_ready;

    modport master (
        output gnt_valid,
        output gnt_id,
        input  gnt_ready
    );

    modport slave (
        input  gnt_valid,
        input  gnt_id,
        output gnt_ready
    );

endinterface

// File: rtl/edge_req_arbiter.sv
// -----------------------------------------------------------------------------
// edge_req_arbiter
//   Round-robin scheduler that lets N level inputs share one downstream
//   resource. Every channel runs a two-flop rising-edge detector; each detected
//   edge becomes a pending request, and pending requests are granted one at a
//   time over a valid/ready handshake.
//
//   Build option:
//     EDGE_ARB_PCNT_EN  undefined : one pending flag per channel
//     EDGE_ARB_PCNT_EN  defined   : PCW-bit saturating pending counter per
//                                   channel in place of the flag
//
//   Parameters:
//     N    number of request channels (2..16)
//     IDW  grant ID width, must be $clog2(N)
//     PCW  pending counter width (counter build only)
//
//   Ports:
//     clk      clock, all state updates on the rising edge
//     reset    synchronous reset, active high
//     D_in     request levels, one per channel (already synchronised upstream)
//     ovf_clr  clears all overflow flags (a same-cycle set wins)
//     ovf      sticky per-channel flag, set when a request edge is dropped
//     gnt      grant handshake (master side): gnt_valid / gnt_id / gnt_ready
// -----------------------------------------------------------------------------
module edge_req_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2,
    parameter int unsigned PCW = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N-1:0]              D_in,
    input  logic                      ovf_clr,
    output logic [N-1:0]              ovf,
    edge_req_arbiter_if.master        gnt
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // -------------------------------------------------------------------------
    if (N < 2 || N > 16) begin : g_bad_n
        $error("edge_req_arbiter: N must be in 2..16");
    end

    if (IDW != $clog2(N)) begin : g_bad_idw
        $error("edge_req_arbiter: IDW must equal $clog2(N)");
    end

    if (PCW < 1 || PCW > 16) begin : g_bad_pcw
        $error("edge_req_arbiter: PCW must be in 1..16");
    end

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);

    state_t         r_state;
    logic           r_gnt_valid;
    logic [IDW-1:0] r_gnt_id;
    logic [IDW-1:0] r_ptr;
    logic [N-1:0]   r_q1;
    logic [N-1:0]   r_q2;
    logic [N-1:0]   r_ovf;

    logic [N-1:0]   w_edge;
    logic [N-1:0]   w_pending;
    logic [N-1:0]   w_take;
    logic [N-1:0]   w_drop;
    logic           w_any;
    logic [IDW-1:0] w_sel;

    // -------------------------------------------------------------------------
    // Two-flop rising-edge detector per channel
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q1 <= '0;
            r_q2 <= '0;
        end else begin
            r_q1 <= D_in;
            r_q2 <= r_q1;
        end
    end

    assign w_edge = r_q1 & ~r_q2;

    // -------------------------------------------------------------------------
    // Pending storage
    // -------------------------------------------------------------------------
`ifdef EDGE_ARB_PCNT_EN

    logic [PCW-1:0] r_pcnt [N];

    always_comb begin
        w_pending = '0;
        w_drop    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_pending[i] = (r_pcnt[i] != '0);
            // A full counter cannot absorb an edge unless a grant frees a slot
            // in the same cycle.
            w_drop[i]    = w_edge[i] & (r_pcnt[i] == '1) & ~w_take[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < N; i++) begin
                r_pcnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                case ({w_edge[i], w_take[i]})
                    2'b10: begin
                        if (r_pcnt[i] != '1) begin
                            r_pcnt[i] <= r_pcnt[i] + 1'b1;
                        end
                    end
                    2'b01: begin
                        r_pcnt[i] <= r_pcnt[i] - 1'b1;
                    end
                    default: begin
                        // no change, or increment and decrement cancel
                    end
                endcase
            end
        end
    end

`else

    logic [N-1:0] r_pend;

    assign w_pending = r_pend;
    assign w_drop    = w_edge & r_pend & ~w_take;

    // Set has priority over the grant clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_take) | w_edge;
        end
    end

`endif

    // -------------------------------------------------------------------------
    // Round-robin selection: first pending channel at or after r_ptr, wrapping
    // -------------------------------------------------------------------------
    always_comb begin
        int unsigned idx;
        idx   = 0;
        w_any = 1'b0;
        w_sel = '0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = int'(r_ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!w_any && w_pending[idx]) begin
                w_any = 1'b1;
                w_sel = IDW'(idx);
            end
        end
    end

    // One-hot of the channel granted this cycle (only when leaving IDLE).
    always_comb begin
        w_take = '0;
        if (r_state == S_IDLE && w_any) begin
            w_take[w_sel] = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Grant FSM with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_ptr       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt_id    <= w_sel;
                        r_gnt_valid <= 1'b1;
                        r_state     <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (gnt.gnt_ready) begin
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= (r_gnt_id == LAST_ID) ? '0 : r_gnt_id + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sticky overflow flags: a same-cycle set wins over ovf_clr
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (ovf_clr ? '0 : r_ovf) | w_drop;
        end
    end

    assign gnt.gnt_valid = r_gnt_valid;
    assign gnt.gnt_id    = r_gnt_id;
    assign ovf           = r_ovf;

endmodule

// File: doc/edge_req_arbiter.md
# edge_req_arbiter

Round-robin scheduler that lets N asynchronous-to-logic level inputs share one downstream resource, such as a shared counter or display update path. Each input passes through the same two-flop rising-edge detector used throughout the design. Each detected edge becomes a pending request. Pending requests are granted one at a time to the resource over a valid/ready handshake. Typically the block sits between the button/switch front end and a single shared incrementer.

## Interface
- `N`, default 4: number of request channels; valid range 2–16.
- `IDW`, default 2: grant ID width; must equal ceil(log2(N)).
- `PCW`, default 3: pending counter width; used only when `EDGE_ARB_PCNT_EN` is defined.
- `clk` input, 1 bit: single clock; all state updates on posedge.
- `reset` input, 1 bit: synchronous reset, active-high.
- `D_in` input, N bits: request levels, one per channel.
- `gnt_ready` input, 1 bit: the resource accepts the current grant.
- `ovf_clr` input, 1 bit: clears all `ovf` bits.
- `gnt_valid` output, 1 bit: a grant is being presented to the resource.
- `gnt_id` output, IDW bits: channel being granted; stable while `gnt_valid`=1.
- `ovf` output, N bits: sticky per-channel flag, set when a request is dropped.

## Operation
- **Edge detect, per channel i:**
  - `Q1[i]`<=`D_in[i]`, then `Q2[i]`<=`Q1[i]`.
  - `edge[i]` = `Q1[i]` & ~`Q2[i]`.
  - A level held high yields exactly one edge.
- **Pending state** (flag mode, macro off): `pend[i]` is set by `edge[i]` and cleared when channel i is granted.
  - If `edge[i]` arrives while `pend[i]`=1 and i is not being granted that cycle, the edge is dropped and `ovf[i]`<=1.
  - If the grant clears `pend[i]` in the same cycle that `edge[i]` arrives, set wins: `pend[i]`=1.
- **FSM** has two states, IDLE and GRANT; reset state is IDLE.
  - IDLE, no pending: stay in IDLE.
  - IDLE, any `pend`: select the first pending channel searching from `ptr` upward, with wrap-around (ptr, ptr+1, …, N-1, 0, …).
    - `gnt_id`<=sel, `gnt_valid`<=1, clear `pend[sel]`, go to GRANT.
  - GRANT, `gnt_ready`=0: hold; `gnt_id` and `gnt_valid` do not change.
  - GRANT, `gnt_ready`=1: handshake completes.
    - `gnt_valid`<=0, `ptr`<=(`gnt_id`+1) mod N, go to IDLE.
- `ptr` wraps N-1 to 0. When N is not a power of two, `ptr` never takes a value ≥N.
- **Overflow flags:**
  - `ovf` bits are set only by dropped edges.
  - `ovf_clr` clears all `ovf` bits.
  - If a set and `ovf_clr` occur in the same cycle, set wins.
- **Reset values:** `gnt_valid`=0, `gnt_id`=0, `ovf`=0, `ptr`=0, `pend`=0, `Q1`=`Q2`=0.
- **Reset mid-grant:** the grant is abandoned and all pending requests are lost.

## Timing
- `D_in[i]` rises and is first sampled at edge k:
  - `edge[i]` is high in cycle k→k+1.
  - `pend[i]` is set at k+1.
  - `gnt_valid` rises at k+2 if the FSM is idle.
- Total latency is 2 cycles from the first sampling edge to `gnt_valid`.
- Grant throughput is at most one grant every 2 cycles (GRANT, then IDLE), even with `gnt_ready` tied high.
- `gnt_valid` and `gnt_id` are registered outputs; they have no combinational path from `gnt_ready` or `D_in`.
- `D_in` is not synchronized here. A metastability synchronizer upstream is the front end's responsibility.

## Configuration
- **`EDGE_ARB_PCNT_EN` undefined:** one pending flag per channel; behaviour as described above.
- **`EDGE_ARB_PCNT_EN` defined:** each channel has a PCW-bit saturating pending counter in place of the flag.
  - The counter increments on `edge[i]`.
  - It decrements when channel i is granted.
  - Same-cycle increment and decrement leave it unchanged.
  - A channel is pending when its counter is ≠0.
  - An edge arriving at 2^PCW−1 without a same-cycle grant is dropped and sets `ovf[i]`.

## Test plan
- **Single request:** reset, `gnt_ready`=1, pulse `D_in`=4'b0100 for 3 cycles.
  - Expect `gnt_valid`=1 with `gnt_id`=2 exactly once, 2 cycles after the first sampling edge; `ovf`=0.
- **Round-robin:** `D_in` 0→4'b1011 simultaneously, `gnt_ready`=1.
  - Expect grants in order 0,1,3, spaced 2 cycles apart; `ptr` ends at 0.
- **Backpressure:** `gnt_ready`=0 for 5 cycles during a grant to channel 1.
  - Expect `gnt_valid`=1 and `gnt_id`=1 held for the whole stall.
  - Raise `gnt_ready`: `gnt_valid`=0 next cycle.
- **Overflow** (flag mode): hold `gnt_ready`=0 while channel 0 is granted, then produce two more edges on channel 0.
  - Expect `ovf[0]`=1; exactly 2 grants to channel 0 in total.
  - Pulse `ovf_clr`: `ovf`=0.
- **Reset mid-grant:** assert `reset` for 1 cycle while `gnt_valid`=1.
  - Expect `gnt_valid`=0 and `gnt_id`=0 after the reset edge, and no grant afterwards until new edges arrive.
- **Counter mode** (`EDGE_ARB_PCNT_EN`, PCW=3): 9 edges on channel 3 with `gnt_ready`=0.
  - Expect `ovf[3]`=1.
  - Release `gnt_ready`: exactly 8 grants to channel 3 (1 in flight + 7 counted).
